// File: rtl/top_level_pkg.sv
// Shared definitions for the Hamming(16,11) SECDED encoder engine.
// Holds the FSM states, the fixed memory map and the parity function.
package top_level_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LD_LO,
        LD_HI,
        ST_LO,
        ST_HI,
        DONE
    } state_t;

    localparam logic [3:0] N_MSG    = 4'd15;
    localparam logic [7:0] IN_BASE  = 8'd0;
    localparam logic [7:0] OUT_BASE = 8'd30;

    // Codeword bit j (1..15) is Hamming position j; bit 0 is the overall parity.
    function automatic logic [15:0] hamming_encode(input logic [11:1] d);
        logic p8;
        logic p4;
        logic p2;
        logic p1;
        logic p0;
        p8 = ^d[11:5];
        p4 = d[11] ^ d[10] ^ d[9] ^ d[8] ^ d[4] ^ d[3] ^ d[2];
        p2 = d[11] ^ d[10] ^ d[7] ^ d[6] ^ d[4] ^ d[3] ^ d[1];
        p1 = d[11] ^ d[9] ^ d[7] ^ d[5] ^ d[4] ^ d[2] ^ d[1];
        p0 = (^d) ^ p8 ^ p4 ^ p2 ^ p1;
        return {d[11:5], p8, d[4:2], p4, d[1], p2, p1, p0};
    endfunction

endpackage

// File: rtl/top_level_data_mem.sv
// 256x8 data memory: asynchronous read, synchronous write, single shared address.
// Contents survive reset; benches load and inspect the core array directly.
module data_mem (
    input  logic       CLK,
    input  logic       we,
    input  logic [7:0] addr,
    input  logic [7:0] wdata,
    output logic [7:0] rdata
);

    logic [7:0] core [0:255];

    assign rdata = core[addr];

    always_ff @(posedge CLK) begin
        if (we) begin
            core[addr] <= wdata;
        end
    end

endmodule

// File: rtl/top_level_instr_rom.sv
// 256x9 program ROM, loaded from outside through the inst_rom array.
// The fixed-function encoder does not depend on its contents.
module instr_rom (
    input  logic [7:0] addr,
    output logic [8:0] data
);

    logic [8:0] inst_rom [0:255];

    assign data = inst_rom[addr];

endmodule

// File: rtl/top_level.sv
// Hamming(16,11) SECDED encoder: reads 15 packed messages from data memory,
// writes the 16-bit codewords back at OUT_BASE, then raises halt.
module top_level
    import top_level_pkg::*;
(
    input  logic CLK,
    input  logic rst_n,
    input  logic start,
    output logic halt
);

    localparam logic [3:0] LAST_IDX = N_MSG - 4'd1;

    state_t      state;
    logic [3:0]  msgIdx;
    logic [7:0]  dataLo;
    logic [2:0]  dataHi;
    logic [15:0] codeWord;
    logic [7:0]  msgOff;
    logic [7:0]  memAddr;
    logic        memWe;
    logic [7:0]  memWdata;
    logic [7:0]  memRdata;
    logic [8:0]  romWord;

    assign msgOff   = {3'b000, msgIdx, 1'b0};
    assign codeWord = hamming_encode({dataHi, dataLo});

    always_ff @(posedge CLK or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            msgIdx <= '0;
            dataLo <= '0;
            dataHi <= '0;
            halt   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        msgIdx <= '0;
                        state  <= LD_LO;
                    end
                end
                LD_LO: begin
                    dataLo <= memRdata;
                    state  <= LD_HI;
                end
                LD_HI: begin
                    dataHi <= memRdata[2:0];
                    state  <= ST_LO;
                end
                ST_LO: begin
                    state <= ST_HI;
                end
                ST_HI: begin
                    if (msgIdx == LAST_IDX) begin
                        state <= DONE;
                        halt  <= 1'b1;
                    end else begin
                        msgIdx <= msgIdx + 4'd1;
                        state  <= LD_LO;
                    end
                end
                DONE: begin
                    if (start) begin
                        msgIdx <= '0;
                        halt   <= 1'b0;
                        state  <= LD_LO;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // One memory access per cycle: the state alone picks the address and the write.
    always_comb begin
        memAddr  = IN_BASE + msgOff;
        memWe    = 1'b0;
        memWdata = codeWord[7:0];
        case (state)
            LD_HI: begin
                memAddr = IN_BASE + msgOff + 8'd1;
            end
            ST_LO: begin
                memAddr = OUT_BASE + msgOff;
                memWe   = 1'b1;
            end
            ST_HI: begin
                memAddr  = OUT_BASE + msgOff + 8'd1;
                memWe    = 1'b1;
                memWdata = codeWord[15:8];
            end
            default: begin
            end
        endcase
    end

    data_mem dm1 (
        .CLK   (CLK),
        .we    (memWe),
        .addr  (memAddr),
        .wdata (memWdata),
        .rdata (memRdata)
    );

    instr_rom instr_ROM1 (
        .addr (memAddr),
        .data (romWord)
    );

endmodule

// File: tb/tb_top_level.sv
// Self-checking bench for the Hamming(16,11) encoder top: table vectors,
// random messages against a position-based Hamming model, and control corner cases.
module tb_top_level;

    logic CLK;
    logic rst_n;
    logic start;
    logic halt;

    int testCount;
    int failCount;

    logic [7:0] expMem [0:255];
    logic [7:0] inLo   [0:14];
    logic [7:0] inHi   [0:14];

    typedef struct {
        string       name;
        logic [7:0]  lo;
        logic [7:0]  hi;
        logic [15:0] expCw;
    } vec_t;

    vec_t vecs [4];

    top_level dut (
        .CLK   (CLK),
        .rst_n (rst_n),
        .start (start),
        .halt  (halt)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Data bits fill non-power-of-two positions in order; each parity covers positions sharing its bit.
    function automatic logic [15:0] refEncode(input logic [10:0] msg);
        logic [15:0] cw;
        logic        par;
        int          k;
        cw = '0;
        k  = 0;
        for (int pos = 1; pos < 16; pos++) begin
            if ((pos & (pos - 1)) != 0) begin
                cw[pos] = msg[k];
                k++;
            end
        end
        for (int p = 1; p < 16; p = p * 2) begin
            par = 1'b0;
            for (int pos = 1; pos < 16; pos++) begin
                if ((pos & p) != 0) par = par ^ cw[pos];
            end
            cw[p] = par;
        end
        cw[0] = ^cw[15:1];
        return cw;
    endfunction

    task automatic checkOutput(input string name, input logic [15:0] actual, input logic [15:0] expected);
        testCount++;
        if (actual !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got 0x%04h, expected 0x%04h", name, actual, expected);
        end
    endtask

    task automatic presetMem();
        logic [7:0] v;
        for (int a = 0; a < 256; a++) begin
            v = 8'($urandom);
            if (a >= 30 && a < 60) v = 8'hA5;
            dut.dm1.core[a] = v;
            expMem[a] = v;
        end
    endtask

    task automatic applyStimulus(input int slot, input logic [7:0] lo, input logic [7:0] hi);
        inLo[slot] = lo;
        inHi[slot] = hi;
        dut.dm1.core[2 * slot]     = lo;
        dut.dm1.core[2 * slot + 1] = hi;
        expMem[2 * slot]           = lo;
        expMem[2 * slot + 1]       = hi;
    endtask

    task automatic expectSlot(input int slot, input logic [15:0] cw);
        expMem[30 + 2 * slot] = cw[7:0];
        expMem[31 + 2 * slot] = cw[15:8];
    endtask

    task automatic expectModel(input int nSlots);
        for (int i = 0; i < nSlots; i++) expectSlot(i, refEncode({inHi[i][2:0], inLo[i]}));
    endtask

    task automatic checkMemory(input string tag);
        for (int a = 0; a < 256; a++)
            checkOutput($sformatf("%s core[%0d]", tag, a), {8'h00, dut.dm1.core[a]}, {8'h00, expMem[a]});
    endtask

    // start is high at the sampling edge E0, then for edges up to holdEdges and a 3-edge glitch at glitchAt.
    task automatic runEncoder(input int holdEdges, input int glitchAt, output int edges);
        @(negedge CLK);
        start = 1'b1;
        @(posedge CLK);
        edges = 1;
        #1;
        start = (holdEdges > 1);
        while (!halt && edges < 200) begin
            @(posedge CLK);
            edges++;
            #1;
            start = (edges < holdEdges) || (glitchAt > 0 && edges >= glitchAt && edges < glitchAt + 3);
        end
        start = 1'b0;
    endtask

    int edges;

    initial begin
        testCount = 0;
        failCount = 0;
        rst_n = 1'b0;
        start = 1'b0;

        vecs[0] = '{"msg001",  8'h01, 8'h00, 16'h000F};
        vecs[1] = '{"msg400",  8'h00, 8'h04, 16'h8117};
        vecs[2] = '{"msg7FFj", 8'hFF, 8'hFF, 16'hFFFF};
        vecs[3] = '{"msg000j", 8'h00, 8'hF8, 16'h0000};

        repeat (3) @(negedge CLK);
        checkOutput("haltInReset", {15'd0, halt}, 16'h0000);
        rst_n = 1'b1;
        repeat (4) @(negedge CLK);
        checkOutput("haltIdle", {15'd0, halt}, 16'h0000);

        // All-zero messages
        presetMem();
        for (int i = 0; i < 15; i++) applyStimulus(i, 8'h00, 8'h00);
        for (int i = 0; i < 15; i++) expectSlot(i, 16'h0000);
        runEncoder(1, 0, edges);
        checkOutput("zeroHaltEdges", 16'(edges), 16'd61);
        checkMemory("zero");

        // Table vectors in slots 0..3, random messages with junk upper bits elsewhere; long start pulse
        presetMem();
        for (int i = 0; i < 4; i++) applyStimulus(i, vecs[i].lo, vecs[i].hi);
        for (int i = 4; i < 15; i++) applyStimulus(i, 8'($urandom), 8'($urandom));
        expectModel(15);
        for (int i = 0; i < 4; i++) expectSlot(i, vecs[i].expCw);
        runEncoder(10, 0, edges);
        checkOutput("longPulseEdges", 16'(edges), 16'd61);
        checkMemory("table");
        for (int i = 0; i < 4; i++)
            checkOutput(vecs[i].name, {dut.dm1.core[31 + 2 * i], dut.dm1.core[30 + 2 * i]}, vecs[i].expCw);

        // Restart from DONE with a mid-run start glitch
        repeat (5) @(negedge CLK);
        checkOutput("haltHeldDone", {15'd0, halt}, 16'h0001);
        presetMem();
        for (int i = 0; i < 15; i++) applyStimulus(i, 8'($urandom), 8'($urandom));
        expectModel(15);
        runEncoder(1, 25, edges);
        checkOutput("restartEdges", 16'(edges), 16'd61);
        checkMemory("restart");

        // Reset mid-run after edge E22: messages 0..4 finished, nothing more written
        presetMem();
        for (int i = 0; i < 15; i++) applyStimulus(i, 8'($urandom), 8'($urandom));
        expectModel(5);
        @(negedge CLK);
        start = 1'b1;
        @(posedge CLK);
        #1;
        start = 1'b0;
        #1;
        checkOutput("haltDropOnStart", {15'd0, halt}, 16'h0000);
        repeat (22) @(posedge CLK);
        #1;
        rst_n = 1'b0;
        #1;
        checkOutput("haltAbort", {15'd0, halt}, 16'h0000);
        repeat (3) @(negedge CLK);
        rst_n = 1'b1;
        repeat (80) @(posedge CLK);
        #1;
        checkOutput("haltAfterAbort", {15'd0, halt}, 16'h0000);
        checkMemory("abort");

        // Full run after the abort
        presetMem();
        for (int i = 0; i < 15; i++) applyStimulus(i, 8'($urandom), 8'($urandom));
        expectModel(15);
        runEncoder(1, 0, edges);
        checkOutput("postAbortEdges", 16'(edges), 16'd61);
        checkMemory("postAbort");

        $display("[TB] %0d tests run, %0d failed", testCount, failCount);
        $finish;
    end

endmodule
